// File: rtl/dds_multi_profile_ctrl.sv
// Multi-channel DDS parameter controller: shadow/active double-buffered tone
// parameters with mask-atomic commits and a per-channel linear frequency ramp.
module dds_multi_profile_ctrl #(
    parameter int unsigned NUM_CH  = 4,
    parameter int unsigned FREQ_W  = 48,
    parameter int unsigned AMP_W   = 14,
    parameter int unsigned PHASE_W = 14
) (
    input  logic                        CLK100MHZ,
    input  logic                        reset,
    input  logic                        cmd_valid,
    output logic                        cmd_ready,
    input  logic [63:0]                 cmd_data,
    output logic [NUM_CH*FREQ_W-1:0]    freq,
    output logic [NUM_CH*AMP_W-1:0]     amp,
    output logic [NUM_CH*PHASE_W-1:0]   phase,
    output logic [NUM_CH*AMP_W-1:0]     amp_offset,
    output logic [NUM_CH*64-1:0]        time_offset,
    output logic [NUM_CH-1:0]           ramp_active,
    output logic [NUM_CH-1:0]           update_strobe,
    output logic                        cmd_error
);

    localparam int unsigned CNT_W = 32;
    localparam int unsigned TOFF_W = 64;

    localparam logic [3:0] OP_SET_FREQ       = 4'h0;
    localparam logic [3:0] OP_SET_AMP_PHASE  = 4'h1;
    localparam logic [3:0] OP_SET_AMP_OFFSET = 4'h2;
    localparam logic [3:0] OP_SET_TIME_OFF   = 4'h3;
    localparam logic [3:0] OP_SET_RAMP_STEP  = 4'h4;
    localparam logic [3:0] OP_SET_RAMP_COUNT = 4'h5;
    localparam logic [3:0] OP_COMMIT         = 4'h8;
    localparam logic [3:0] OP_RAMP_START     = 4'h9;
    localparam logic [3:0] OP_RAMP_STOP      = 4'hA;

    logic [3:0]        op;
    logic [3:0]        ch;
    logic [55:0]       payload;
    logic [NUM_CH-1:0] mask;
    logic              accept;
    logic              ch_op;
    logic              mask_op;
    logic              ch_ok;
    logic              legal;
    logic [NUM_CH-1:0] wr_sel;
    logic [NUM_CH-1:0] commit_sel;
    logic [NUM_CH-1:0] start_sel;
    logic [NUM_CH-1:0] stop_sel;

    logic [FREQ_W-1:0]  sh_freq  [NUM_CH];
    logic [AMP_W-1:0]   sh_amp   [NUM_CH];
    logic [PHASE_W-1:0] sh_phase [NUM_CH];
    logic [AMP_W-1:0]   sh_aoff  [NUM_CH];
    logic [TOFF_W-1:0]  sh_toff  [NUM_CH];
    logic [FREQ_W-1:0]  sh_step  [NUM_CH];
    logic [CNT_W-1:0]   sh_count [NUM_CH];

    logic [FREQ_W-1:0]  act_freq  [NUM_CH];
    logic [AMP_W-1:0]   act_amp   [NUM_CH];
    logic [PHASE_W-1:0] act_phase [NUM_CH];
    logic [AMP_W-1:0]   act_aoff  [NUM_CH];
    logic [TOFF_W-1:0]  act_toff  [NUM_CH];
    logic [FREQ_W-1:0]  act_step  [NUM_CH];
    logic [CNT_W-1:0]   act_count [NUM_CH];

    // Command decode into per-channel select vectors; illegal commands select nothing.
    always_comb begin
        op         = cmd_data[63:60];
        ch         = cmd_data[59:56];
        payload    = cmd_data[55:0];
        mask       = payload[NUM_CH-1:0];
        accept     = cmd_valid && cmd_ready;
        ch_op      = (op <= OP_SET_RAMP_COUNT);
        mask_op    = (op == OP_COMMIT) || (op == OP_RAMP_START) || (op == OP_RAMP_STOP);
        ch_ok      = ({1'b0, ch} < 5'(NUM_CH));
        legal      = (ch_op && ch_ok) || (mask_op && (mask != '0));
        wr_sel     = '0;
        commit_sel = '0;
        start_sel  = '0;
        stop_sel   = '0;
        for (int k = 0; k < NUM_CH; k++) begin
            wr_sel[k]     = accept && legal && ch_op && (ch == 4'(k));
            commit_sel[k] = accept && legal && (op == OP_COMMIT) && mask[k];
            start_sel[k]  = accept && legal && (op == OP_RAMP_START) && mask[k];
            stop_sel[k]   = accept && legal && (op == OP_RAMP_STOP) && mask[k];
        end
    end

    always_ff @(posedge CLK100MHZ) begin
        if (reset) begin
            cmd_ready     <= 1'b0;
            cmd_error     <= 1'b0;
            update_strobe <= '0;
            ramp_active   <= '0;
            for (int k = 0; k < NUM_CH; k++) begin
                sh_freq[k]   <= '0;
                sh_amp[k]    <= '0;
                sh_phase[k]  <= '0;
                sh_aoff[k]   <= '0;
                sh_toff[k]   <= '0;
                sh_step[k]   <= '0;
                sh_count[k]  <= '0;
                act_freq[k]  <= '0;
                act_amp[k]   <= '0;
                act_phase[k] <= '0;
                act_aoff[k]  <= '0;
                act_toff[k]  <= '0;
                act_step[k]  <= '0;
                act_count[k] <= '0;
            end
        end else begin
            cmd_ready <= 1'b1;
            cmd_error <= accept && !legal;
            for (int k = 0; k < NUM_CH; k++) begin
                update_strobe[k] <= 1'b0;
                if (wr_sel[k]) begin
                    case (op)
                        OP_SET_FREQ:       sh_freq[k]  <= payload[FREQ_W-1:0];
                        OP_SET_AMP_PHASE: begin
                            sh_amp[k]   <= AMP_W'(payload[27:14]);
                            sh_phase[k] <= PHASE_W'(payload[13:0]);
                        end
                        OP_SET_AMP_OFFSET: sh_aoff[k]  <= AMP_W'(payload[13:0]);
                        OP_SET_TIME_OFF:   sh_toff[k]  <= {8'h00, payload};
                        OP_SET_RAMP_STEP:  sh_step[k]  <= payload[FREQ_W-1:0];
                        OP_SET_RAMP_COUNT: sh_count[k] <= payload[CNT_W-1:0];
                        default: ;
                    endcase
                end
                // Mask commands take priority over this edge's ramp increment.
                if (commit_sel[k]) begin
                    act_freq[k]      <= sh_freq[k];
                    act_amp[k]       <= sh_amp[k];
                    act_phase[k]     <= sh_phase[k];
                    act_aoff[k]      <= sh_aoff[k];
                    act_toff[k]      <= sh_toff[k];
                    act_count[k]     <= '0;
                    ramp_active[k]   <= 1'b0;
                    update_strobe[k] <= 1'b1;
                end else if (start_sel[k] && (sh_count[k] != '0)) begin
                    act_step[k]    <= sh_step[k];
                    act_count[k]   <= sh_count[k];
                    ramp_active[k] <= 1'b1;
                end else if (stop_sel[k]) begin
                    act_count[k]   <= '0;
                    ramp_active[k] <= 1'b0;
                end else if (act_count[k] != '0) begin
                    act_freq[k]      <= act_freq[k] + act_step[k];
                    act_count[k]     <= act_count[k] - CNT_W'(1);
                    ramp_active[k]   <= (act_count[k] != CNT_W'(1));
                    update_strobe[k] <= 1'b1;
                end
            end
        end
    end

    for (genvar k = 0; k < NUM_CH; k++) begin : g_out
        assign freq[k*FREQ_W +: FREQ_W]        = act_freq[k];
        assign amp[k*AMP_W +: AMP_W]           = act_amp[k];
        assign phase[k*PHASE_W +: PHASE_W]     = act_phase[k];
        assign amp_offset[k*AMP_W +: AMP_W]    = act_aoff[k];
        assign time_offset[k*TOFF_W +: TOFF_W] = act_toff[k];
    end

endmodule
